// File: rtl/somador_pkg.sv
// Shared types and constants for the sequential BCD adder: FSM states,
// active-low seven-segment patterns (literal bit order a..g) and a power-of-ten helper.
package somador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_CONV,
        ST_DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0000001;
            4'd1:    p = 7'b1001111;
            4'd2:    p = 7'b0010010;
            4'd3:    p = 7'b0000110;
            4'd4:    p = 7'b1001100;
            4'd5:    p = 7'b0100100;
            4'd6:    p = 7'b0100000;
            4'd7:    p = 7'b0001111;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0000100;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decod.sv
// One BCD digit to active-low seven-segment pattern; codes above 9 show blank.
module seg7_decod
    import somador_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_of(bcd);

endmodule

// File: rtl/somador_bcd_seq.sv
// Registered W-bit adder with sequential shift-add-3 binary-to-BCD conversion and
// DIGITS seven-segment outputs. Define SOMADOR_SIGNED_EN for two's-complement operands and HEX_SIGN.
module somador_bcd_seq
    import somador_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [W-1:0]        A,
    input  logic [W-1:0]        B,
    input  logic                TE0,
    output logic [W:0]          S,
    output logic                BUSY,
    output logic                DONE,
    output logic [7*DIGITS-1:0] HEX
`ifdef SOMADOR_SIGNED_EN
    ,
    output logic [6:0]          HEX_SIGN
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + W + 1;
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (pow10(DIGITS) <= (longint'(1) << (W + 1)) - 1) begin : g_bad_digits
        $error("somador_bcd_seq: DIGITS too small to show every W+1 bit sum");
    end

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic                te0_q, te0_d;
    logic [W:0]          sum_q, sum_d;
    logic [W:0]          s_q, s_d;
    logic [SW-1:0]       sh_q, sh_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
`ifdef SOMADOR_SIGNED_EN
    logic                neg_q, neg_d;
    logic [6:0]          hex_sign_q, hex_sign_d;
`endif

    logic [W:0]          sum_calc;
    logic [W:0]          mag;
    logic [SW-1:0]       sh_adj;
    logic [SW-1:0]       sh_shift;
    logic [BW-1:0]       bcd_final;
    logic [7*DIGITS-1:0] seg_raw;
    logic [7*DIGITS-1:0] hex_blanked;
    logic                higher_nz;

`ifdef SOMADOR_SIGNED_EN
    assign sum_calc = {a_q[W-1], a_q} + {b_q[W-1], b_q} + (W+1)'(te0_q);
    assign mag      = sum_calc[W] ? ((W+1)'(0) - sum_calc) : sum_calc;
`else
    assign sum_calc = {1'b0, a_q} + {1'b0, b_q} + (W+1)'(te0_q);
    assign mag      = sum_calc;
`endif

    // Double-dabble step: correct every BCD nibble >= 5 before the shift.
    assign sh_adj[W:0] = sh_q[W:0];
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        logic [3:0] nib;
        assign nib = sh_q[W+1+4*gi +: 4];
        assign sh_adj[W+1+4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    assign sh_shift  = {sh_adj[SW-2:0], 1'b0};
    assign bcd_final = sh_shift[SW-1 -: BW];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
        seg7_decod u_dec (
            .bcd (bcd_final[4*gi +: 4]),
            .seg (seg_raw[7*gi +: 7])
        );
    end

    always_comb begin
        higher_nz   = 1'b0;
        hex_blanked = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            higher_nz = higher_nz | (bcd_final[4*k +: 4] != 4'd0);
            hex_blanked[7*k +: 7] = (k == 0 || higher_nz) ? seg_raw[7*k +: 7] : SEG_BLANK;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        te0_d   = te0_q;
        sum_d   = sum_q;
        s_d     = s_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hex_d   = hex_q;
`ifdef SOMADOR_SIGNED_EN
        neg_d      = neg_q;
        hex_sign_d = hex_sign_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    te0_d   = TE0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d   = sum_calc;
                sh_d    = {{BW{1'b0}}, mag};
                cnt_d   = CNT_LOAD;
                state_d = ST_CONV;
`ifdef SOMADOR_SIGNED_EN
                neg_d   = sum_calc[W];
`endif
            end
            ST_CONV: begin
                sh_d  = sh_shift;
                cnt_d = cnt_q - CNT_ONE;
                // Final shift: publish sum and display together so both appear with DONE.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    s_d     = sum_q;
                    hex_d   = hex_blanked;
`ifdef SOMADOR_SIGNED_EN
                    hex_sign_d = neg_q ? SEG_MINUS : SEG_BLANK;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            te0_q   <= 1'b0;
            sum_q   <= '0;
            s_q     <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= {DIGITS{SEG_BLANK}};
`ifdef SOMADOR_SIGNED_EN
            neg_q      <= 1'b0;
            hex_sign_q <= SEG_BLANK;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            te0_q   <= te0_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
`ifdef SOMADOR_SIGNED_EN
            neg_q      <= neg_d;
            hex_sign_q <= hex_sign_d;
`endif
        end
    end

    assign S    = s_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HEX  = hex_q;
`ifdef SOMADOR_SIGNED_EN
    assign HEX_SIGN = hex_sign_q;
`endif

endmodule

// File: tb/tb_somador_bcd_seq.sv
// Scoreboard bench for somador_bcd_seq (W=8, DIGITS=3): directed vectors push expected
// results; a negedge monitor pops and compares whenever DONE is seen.
module tb_somador_bcd_seq;

    localparam int W      = 8;
    localparam int DIGITS = 3;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b1111110;
    localparam int BL = 10;

    logic                CLK   = 1'b0;
    logic                RST_N = 1'b0;
    logic                START = 1'b0;
    logic                TE0   = 1'b0;
    logic [W-1:0]        A     = '0;
    logic [W-1:0]        B     = '0;
    logic [W:0]          S;
    logic                BUSY;
    logic                DONE;
    logic [7*DIGITS-1:0] HEX;
`ifdef SOMADOR_SIGNED_EN
    logic [6:0]          HEX_SIGN;
`endif

    typedef struct {
        logic [W:0]          s;
        logic [7*DIGITS-1:0] hex;
        logic [6:0]          sgn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_total = 0;

    always #5 CLK = ~CLK;

    somador_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .A        (A),
        .B        (B),
        .TE0      (TE0),
        .S        (S),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .HEX      (HEX)
`ifdef SOMADOR_SIGNED_EN
        ,
        .HEX_SIGN (HEX_SIGN)
`endif
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] hx(input int d2, input int d1, input int d0);
        return {seg(d2), seg(d1), seg(d0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE) begin
            exp_t e;
            done_total++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: DONE=1 with no pending transaction (S=%0h)", S);
            end else begin
                e = exp_q.pop_front();
                $display("done: S=%0h HEX=%06h (expected S=%0h HEX=%06h)", S, HEX, e.s, e.hex);
                chk("S", 32'(S), 32'(e.s));
                chk("HEX", 32'(HEX), 32'(e.hex));
`ifdef SOMADOR_SIGNED_EN
                chk("HEX_SIGN", 32'(HEX_SIGN), 32'(e.sgn));
`endif
            end
        end
    end

    // Counts negedges after the START edge; n is the cycle index at which DONE was seen.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(negedge CLK);
            n++;
            if (BUSY) nb++;
        end while (!DONE && n < 40);
        if (!DONE) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no DONE within %0d cycles", n);
        end
    endtask

    task automatic push_exp(input logic [W:0] es, input int d2, input int d1, input int d0,
                            input logic neg);
        exp_t e;
        e.s   = es;
        e.hex = hx(d2, d1, d0);
        e.sgn = neg ? MINUS : BLANK;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic te0,
                          input logic [W:0] es, input int d2, input int d1, input int d0,
                          input logic neg);
        int n, nb;
        push_exp(es, d2, d1, d0, neg);
        @(negedge CLK);
        A = a; B = b; TE0 = te0; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = ~a; B = ~b; TE0 = ~te0;
        wait_done(n, nb);
        chk("done_cycle", 32'(n), 32'(W + 3));
        chk("busy_cycles", 32'(nb), 32'(W + 3));
        @(negedge CLK);
        chk("done_pulse", 32'(DONE), 32'd0);
        chk("busy_after", 32'(BUSY), 32'd0);
        chk("S_hold", 32'(S), 32'(es));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, k, base;
        int at[3];

        repeat (2) @(negedge CLK);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_BUSY", 32'(BUSY), 32'd0);
        chk("rst_DONE", 32'(DONE), 32'd0);
        chk("rst_HEX", 32'(HEX), 32'(hx(BL, BL, BL)));
`ifdef SOMADOR_SIGNED_EN
        chk("rst_HEX_SIGN", 32'(HEX_SIGN), 32'(BLANK));
`endif
        RST_N = 1'b1;

`ifdef SOMADOR_SIGNED_EN
        run_op(8'hFB, 8'h02, 1'b0, 9'h1FD, BL, BL, 3, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 9'h100, 2, 5, 6, 1'b1);
        run_op(8'h7F, 8'h7F, 1'b1, 9'h0FF, 2, 5, 5, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0, 9'h1FF, BL, BL, 1, 1'b1);
        run_op(8'h0A, 8'hF6, 1'b1, 9'h001, BL, BL, 1, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 9'h000, BL, BL, 0, 1'b0);
`else
        run_op(8'd200, 8'd100, 1'b0, 9'd300, 3, 0, 0, 1'b0);
        run_op(8'd9,   8'd0,   1'b0, 9'd9,   BL, BL, 9, 1'b0);
        run_op(8'd255, 8'd255, 1'b1, 9'd511, 5, 1, 1, 1'b0);
        run_op(8'd0,   8'd0,   1'b0, 9'd0,   BL, BL, 0, 1'b0);
        run_op(8'd99,  8'd1,   1'b0, 9'd100, 1, 0, 0, 1'b0);
        run_op(8'd45,  8'd50,  1'b1, 9'd96,  BL, 9, 6, 1'b0);
        run_op(8'd128, 8'd127, 1'b1, 9'd256, 2, 5, 6, 1'b0);
`endif

        // START pulses while busy must be ignored.
        base = done_total;
        push_exp(9'd30, BL, 3, 0, 1'b0);
        @(negedge CLK);
        A = 8'd10; B = 8'd20; TE0 = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 3 || n == 7) begin
                A = 8'd99; B = 8'd77; START = 1'b1;
            end else begin
                START = 1'b0;
            end
        end while (!DONE && n < 40);
        START = 1'b0;
        chk("ignore_done_cycle", 32'(n), 32'(W + 3));
        repeat (20) @(negedge CLK);
        chk("ignore_done_count", 32'(done_total - base), 32'd1);

        // START held high re-triggers every W+4 cycles.
        base = done_total;
        for (int i = 0; i < 3; i++) push_exp(9'd4, BL, BL, 4, 1'b0);
        @(negedge CLK);
        A = 8'd1; B = 8'd2; TE0 = 1'b1; START = 1'b1;
        n = 0;
        k = 0;
        while (k < 3 && n < 60) begin
            @(negedge CLK);
            n++;
            if (DONE) begin
                at[k] = n;
                k++;
                if (k == 3) START = 1'b0;
            end
        end
        START = 1'b0;
        chk("held_done_count", 32'(k), 32'd3);
        chk("held_done0", 32'(at[0]), 32'(W + 3));
        chk("held_period1", 32'(at[1] - at[0]), 32'(W + 4));
        chk("held_period2", 32'(at[2] - at[1]), 32'(W + 4));
        repeat (20) @(negedge CLK);
        chk("held_no_extra", 32'(done_total - base), 32'd3);

        // Reset in the middle of conversion discards the operation.
        base = done_total;
        @(negedge CLK);
        A = 8'd50; B = 8'd60; TE0 = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (6) @(negedge CLK);
        chk("pre_rst_busy", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("midrst_S", 32'(S), 32'd0);
        chk("midrst_BUSY", 32'(BUSY), 32'd0);
        chk("midrst_HEX", 32'(HEX), 32'(hx(BL, BL, BL)));
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        chk("midrst_no_done", 32'(done_total - base), 32'd0);
        run_op(8'd123, 8'd45, 1'b0, 9'd168, 1, 6, 8, 1'b0);

        repeat (5) @(negedge CLK);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
